mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port data/instruction memory between two requesters inside cpu_top: instruction fetch (read-only) and load/store (read/write with byte enables).
- Sequences each access through a fixed-latency memory with a small FSM and returns read data to the winning port with a one-cycle done pulse.
- Sits between the core's fetch/LSU logic and the memory macro, so a store followed by a load (for example, sw 50 to address 0, then lw) is serialised correctly.

Parameters:
- AW, 32, address width in bits (byte address, passed through unchanged).
- LATENCY, 2, cycles from the memory-enable cycle to valid mem_rdata; legal range is ≥1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high with if_addr stable until if_done
- if_addr  in  AW  fetch address
- if_done  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  32  fetched word (registered)
- d_req  in  1  data request; held high with addr, we, be and wdata stable until d_done
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  byte enables for stores
- d_addr  in  AW  data address
- d_wdata  in  32  store data
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  32  load data (registered)
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_be  out  4  memory byte enables; 4'hF on reads
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid LATENCY cycles after the mem_en cycle
- busy  out  1  high in any state other than IDLE
- owner  out  1  current or last grant: 0 = fetch, 1 = data

Behaviour:
- Reset values:
  - FSM = IDLE.
  - mem_en, mem_we, if_done, d_done, busy = 0.
  - mem_be, mem_addr, mem_wdata = 0.
  - if_rdata, d_rdata = 0.
  - owner = 0.
  - Latency counter = 0.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: at an edge where any request is high, latch the winner's address, we, be and wdata, set owner, and go to ISSUE.
  - ISSUE: mem_en = 1 for exactly one cycle. Counter loads LATENCY. Go to WAIT.
  - WAIT: counter decrements each edge. When it reaches 0, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to DONE.
  - DONE: the owner's done output is high for exactly one cycle. Go to IDLE.
- Timing:
  - Request sampled at edge E0.
  - mem_en is high in cycle E0..E0+1.
  - mem_rdata is captured at edge E0+1+LATENCY.
  - done is high in the cycle following that edge.
  - Total latency from request sample to done = LATENCY+2 cycles. With LATENCY=2, fetch throughput is one word per 5 cycles.
- Stores:
  - Same timing as loads.
  - d_rdata keeps its previous value.
  - mem_we = 1 and mem_be = d_be only during the ISSUE cycle.
- Arbitration (default):
  - Fixed priority, data port over fetch.
  - A request that arrives while busy waits in place; no request is dropped.
- Requests are ignored during DONE. A requester that keeps req high after done is treated as a new request at the next IDLE edge.
- Port inputs are sampled only in IDLE. Changes to the latched values mid-access have no effect.
- The non-owner's done output never pulses.
- Reset asserted mid-access:
  - Immediate return to IDLE with all outputs cleared.
  - No done pulse is produced.
  - A write whose mem_en was already issued is considered performed.
- LATENCY=1: the counter sits at 1 for one WAIT cycle.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - On simultaneous if_req and d_req in IDLE, grant goes to the port opposite to owner (round-robin).
  - owner resets to 0, so the first contested grant goes to data.
  - Uncontested requests are granted immediately regardless of owner.
- Undefined: fixed data-over-fetch priority. A continuous d_req stream may starve fetch.

Test Plan:
- Store then load, LATENCY=2: d_req with we=1, addr 0, wdata 50, be F; then d_req with we=0, addr 0 → d_done 4 cycles after each sample, d_rdata = 50, exactly 1 mem_en per access.
- Byte-enable store: memory holds 32'h11223344 at 0x4; store 32'hAABBCCDD with be 4'b0011 → subsequent load returns 32'h1122CCDD.
- Contention: if_req and d_req rise on the same edge → data served first. if_done arrives 5 cycles after d_done (owner 1, then 0). if_done never pulses during the data access.
- Fairness (MEM_ARB_FAIR_EN defined): both requests held high for 4 accesses → grant order data, fetch, data, fetch. Macro undefined → data ×4, fetch starved.
- Reset mid-WAIT: assert rst during WAIT of a load → outputs 0 on the same cycle, no done pulse. After release, a new if_req at 0x8 completes normally with the correct word.
- LATENCY=1 build: back-to-back fetches from 0x0 and 0x4 → if_done every 4 cycles with the correct data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a fixed-latency single-port memory
// Define MEM_ARB_FAIR_EN for round-robin on contested grants (default: data over fetch).
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_done,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_store;
  logic          grant_d;

  always_comb begin
    grant_d = 1'b0;
`ifdef MEM_ARB_FAIR_EN
    // contested grant alternates away from the previous owner
    grant_d = d_req && (!if_req || !owner);
`else
    grant_d = d_req;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_store  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            owner  <= grant_d;
            if (grant_d) begin
              is_store  <= d_we;
              mem_we    <= d_we;
              mem_be    <= d_we ? d_be : 4'hF;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              is_store  <= 1'b0;
              mem_we    <= 1'b0;
              mem_be    <= 4'hF;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          mem_be <= 4'hF;
          cnt    <= CW'(LATENCY);
          state  <= WAIT;
        end
        WAIT: begin
          // the edge that would take cnt to zero is the one where mem_rdata is valid
          if (cnt <= CW'(1)) begin
            cnt   <= '0;
            state <= DONE;
            if (owner) begin
              d_done <= 1'b1;
              if (!is_store) d_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench: LATENCY=2 instance plus a LATENCY=1 fetch instance
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst, init;
  logic        if_req, if_done, d_req, d_we, d_done;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_en, mem_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        f1_req, f1_done, f1_ddone, f1_men, f1_mwe, f1_busy, f1_owner;
  logic [31:0] f1_addr, f1_rdata, f1_drdata, f1_maddr, f1_mwdata, f1_mrdata;
  logic [3:0]  f1_mbe;
  logic        zero1;
  logic [3:0]  zero4;
  logic [31:0] zero32;

  logic [31:0] mem [0:15];
  logic [31:0] p0 [0:1];
  logic [31:0] p1;

  exp_t        sbq[$];
  logic [31:0] q1[$];
  int          passed, total;
  logic [31:0] exp_d;

  mem_port_arbiter #(.AW(32), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(f1_req), .if_addr(f1_addr), .if_done(f1_done), .if_rdata(f1_rdata),
    .d_req(zero1), .d_we(zero1), .d_be(zero4), .d_addr(zero32), .d_wdata(zero32),
    .d_done(f1_ddone), .d_rdata(f1_drdata),
    .mem_en(f1_men), .mem_we(f1_mwe), .mem_be(f1_mbe), .mem_addr(f1_maddr),
    .mem_wdata(f1_mwdata), .mem_rdata(f1_mrdata),
    .busy(f1_busy), .owner(f1_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: read data emerges LATENCY cycles after the mem_en cycle, poison otherwise
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h11223344;
      mem[2] <= 32'hCAFE0008;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    p0[0] <= (mem_en && !mem_we) ? mem[mem_addr[5:2]] : 32'hDEADBEEF;
    p0[1] <= p0[0];
    p1    <= f1_men ? mem[f1_maddr[5:2]] : 32'hDEADBEEF;
  end
  assign mem_rdata = p0[1];
  assign f1_mrdata = p1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total = total + 1;
    assert (obs === exp_v) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (if_done || d_done)) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 32'({if_done, d_done}), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("done_port", 32'(d_done), 32'(e.port));
        check("done_single", 32'(if_done & d_done), 32'd0);
        check("owner_at_done", 32'(owner), 32'(e.port));
        check("rdata", e.port ? d_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic access(input logic port, input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] expd);
    int  n, ens;
    bit  seen;
    @(negedge clk);
    if (port) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    sbq.push_back({port, expd});
    n = 0; ens = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_en) begin
        ens++;
        check("issue_we", 32'(mem_we), 32'(we));
        check("issue_be", 32'(mem_be), we ? 32'(be) : 32'hF);
        check("issue_addr", mem_addr, a);
        if (we) check("issue_wdata", mem_wdata, wd);
      end
      if (port ? d_done : if_done) seen = 1;
    end
    d_req = 1'b0; if_req = 1'b0;
    check("access_latency", 32'(n), 32'd4);
    check("mem_en_count", 32'(ens), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, td, ti, nd, t1;
    bit  ok;
    passed = 0; total = 0; exp_d = 32'h0;
    zero1 = 1'b0; zero4 = 4'h0; zero32 = 32'h0;
    rst = 1'b1; init = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    f1_req = 0; f1_addr = 0;
    repeat (3) @(negedge clk);

    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_dones", 32'({if_done, d_done}), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    init = 1'b0; rst = 1'b0;

    access(1, 1, 4'hF, 32'h0, 32'd50, exp_d);
    exp_d = 32'd50;
    access(1, 0, 4'hF, 32'h0, 32'h0, exp_d);
    access(1, 1, 4'b0011, 32'h4, 32'hAABBCCDD, exp_d);
    exp_d = 32'h1122CCDD;
    access(1, 0, 4'hF, 32'h4, 32'h0, exp_d);

    // reset in the middle of a load
    @(negedge clk);
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_outputs", 32'({mem_en, mem_we, busy, owner, if_done, d_done}), 32'd0);
    check("midrst_d_rdata", d_rdata, 32'd0);
    d_req = 0;
    ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (d_done || if_done) ok = 0;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (d_done || if_done) ok = 0;
    end
    check("midrst_no_done", 32'(ok), 32'd1);
    exp_d = 32'h0;
    access(0, 0, 4'hF, 32'h8, 32'h0, 32'hCAFE0008);

    // contention: data first, fetch five cycles later
    @(negedge clk);
    if_req = 1; if_addr = 32'h8;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0;
    sbq.push_back({1'b1, 32'd50});
    sbq.push_back({1'b0, 32'hCAFE0008});
    exp_d = 32'd50;
    n = 0; td = -1; ti = -1;
    while ((td < 0 || ti < 0) && n < 30) begin
      @(negedge clk);
      n++;
      if (d_done) begin td = n; d_req = 0; end
      if (if_done) begin ti = n; if_req = 0; end
    end
    d_req = 0; if_req = 0;
    check("contend_d_latency", 32'(td), 32'd4);
    check("contend_if_gap", 32'(ti - td), 32'd5);

    // sustained contention over four grants
    @(negedge clk);
    if_req = 1; if_addr = 32'h8;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0;
`ifdef MEM_ARB_FAIR_EN
    sbq.push_back({1'b1, 32'd50});
    sbq.push_back({1'b0, 32'hCAFE0008});
    sbq.push_back({1'b1, 32'd50});
    sbq.push_back({1'b0, 32'hCAFE0008});
`else
    repeat (4) sbq.push_back({1'b1, 32'd50});
`endif
    n = 0; nd = 0;
    while (nd < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (d_done || if_done) nd++;
    end
    d_req = 0; if_req = 0;
    check("sustained_grants", 32'(nd), 32'd4);
    repeat (8) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    // LATENCY=1 instance: back-to-back fetches
    q1.push_back(32'd50);
    q1.push_back(32'h1122CCDD);
    @(negedge clk);
    f1_req = 1; f1_addr = 32'h0;
    n = 0; nd = 0; t1 = 0; td = 0;
    while (nd < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (f1_done) begin
        nd++;
        check("lat1_rdata", f1_rdata, (q1.size() > 0) ? q1.pop_front() : 32'hFFFFFFFF);
        if (nd == 1) begin t1 = n; f1_addr = 32'h4; end
        else begin td = n; f1_req = 0; end
      end
    end
    f1_req = 0;
    check("lat1_first_latency", 32'(t1), 32'd3);
    check("lat1_period", 32'(td - t1), 32'd4);
    check("lat1_no_data_done", 32'(f1_ddone), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
